uart_tx_fifo: RTL and testbench

- Buffered byte source feeding the UART transmitter's parallel side (its tx_en / data_in / busy_tx / done_tx handshake).
- Accepts bytes from a local writer into a FIFO and launches each byte as one UART frame.
- Launches the next byte only after the transmitter reports completion of the current one.
- Gives firmware/test logic back-to-back transmission without per-byte handshaking.

---
 rtl/uart_tx_fifo.sv | 99 +++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches one UART frame per entry on the tx_en/tx_busy/tx_done handshake.
// Define UART_TX_FIFO_GAP_EN to insert GAP_CYCLES idle clocks after every completed frame.
module uart_tx_fifo #(
   parameter int DEPTH      = 16,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     tx_en,
   output logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_busy,
   input  logic                     tx_done
);
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1) begin : g_bad_param
      $error("uart_tx_fifo: DEPTH must be a power of two >= 2 and GAP_CYCLES >= 1");
   end

`ifdef UART_TX_FIFO_GAP_EN
   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;
   localparam state_t AFTER_DONE = GAP;
`else
   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
   localparam state_t AFTER_DONE = IDLE;
`endif

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   state_t            state, next;
   logic              push, pop, gap_over;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
   assign count = wr_ptr - rd_ptr;
   assign push  = wr_en && !full;
   assign pop   = state == LAUNCH;

   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;

`ifdef UART_TX_FIFO_GAP_EN
   localparam int GW = $clog2(GAP_CYCLES + 1);
   logic [GW-1:0] gap_cnt;
   assign gap_over = gap_cnt == '0;
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) gap_cnt <= '0;
      else if (rst) gap_cnt <= '0;
      else if (state != GAP) gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (!gap_over) gap_cnt <= gap_cnt - 1'b1;
`else
   assign gap_over = 1'b1;
`endif

   always_comb begin
      next = state;
      case (state)
         IDLE:      next = (!empty && !tx_busy) ? LAUNCH : IDLE;
         LAUNCH:    next = WAIT_BUSY;
         WAIT_BUSY: next = tx_done ? AFTER_DONE : tx_busy ? WAIT_DONE : WAIT_BUSY;
         WAIT_DONE: next = tx_done ? AFTER_DONE : WAIT_DONE;
         default:   next = gap_over ? IDLE : state;
      endcase
   end

   // tx_en and tx_data are registered together so the byte is valid on the same cycle as the pulse.
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         tx_en    <= 1'b0;
         tx_data  <= '0;
      end else if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         tx_en    <= 1'b0;
         tx_data  <= '0;
      end else begin
         state    <= next;
         wr_ptr   <= wr_ptr + {{AW{1'b0}}, push};
         rd_ptr   <= rd_ptr + {{AW{1'b0}}, pop};
         overflow <= overflow | (wr_en & full);
         tx_en    <= next == LAUNCH;
         if (next == LAUNCH) tx_data <= mem[rd_ptr[AW-1:0]];
      end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with a behavioural transmitter.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int GAP_N = 16;
`ifdef UART_TX_FIFO_GAP_EN
   localparam int SPACE = 2 + GAP_N;
`else
   localparam int SPACE = 2;
`endif

   logic       clk = 0, arst_n = 0, rst = 0, wr_en = 0;
   logic [7:0] wr_data = 0;
   logic       full, empty, overflow, tx_en;
   logic [4:0] count;
   logic [7:0] tx_data, cur_m;
   logic       busy_m = 0, hold = 0, tx_done = 0;
   logic       tx_busy;
   bit         model_active = 0, frame_rst = 0;
   int         checks = 0, failures = 0, cyc = 0, frame_len = 20, wcyc;
   logic [7:0] rx_q[$], exp_q[$];
   int         en_cyc_q[$], done_cyc_q[$];

   assign tx_busy = busy_m | hold;

   uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8), .GAP_CYCLES(GAP_N)) dut (
      .clk(clk), .arst_n(arst_n), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      #1;
      if (tx_en) begin
         rx_q.push_back(tx_data);
         en_cyc_q.push_back(cyc);
         check("en_while_busy", tx_busy, 0);
      end
   end

   // Transmitter model: busy two cycles after the launch, done pulse after frame_len busy cycles.
   initial forever begin
      @(negedge clk);
      if (tx_en) begin
         cur_m = tx_data;
         model_active = 1;
         frame_rst = 0;
         repeat (2) @(negedge clk);
         busy_m = 1;
         repeat (frame_len) @(negedge clk);
         busy_m = 0;
         tx_done = 1;
         done_cyc_q.push_back(cyc);
         if (!frame_rst) check("data_hold", tx_data, cur_m);
         @(negedge clk);
         tx_done = 0;
         model_active = 0;
      end
   end

   task automatic wr(input logic [7:0] d, input bit keep);
      @(negedge clk);
      wr_en = 1;
      wr_data = d;
      if (keep) exp_q.push_back(d);
   endtask

   task automatic wr_off();
      @(negedge clk);
      wr_en = 0;
      #1;
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         #1;
         if (empty && !model_active && !tx_en) begin
            ok = 1;
            break;
         end
      end
      check(tag, ok, 1);
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_n"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) check({tag, "_data"}, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
      en_cyc_q.delete();
      done_cyc_q.delete();
   endtask

   initial begin
      bit found;
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      repeat (2) @(negedge clk);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_tx_en", tx_en, 0);
      check("rst_tx_data", tx_data, 0);
      arst_n = 1;
      repeat (3) @(negedge clk);

      frame_len = 100;
      wr(8'hA5, 1);
      wcyc = cyc;
      wr_off();
      wait_idle("single_idle");
      check("single_latency", en_cyc_q.size() > 0 ? en_cyc_q[0] - wcyc : -1, 2);
      check("single_empty", empty, 1);
      check_rx("single");

      frame_len = 20;
      for (int i = 0; i < 16; i++) wr(8'(i), 1);
      wr_off();
      check("burst_count", count, 15);
      check("burst_full", full, 0);
      wait_idle("burst_idle");
      for (int i = 1; i < 16 && i < en_cyc_q.size() && i <= done_cyc_q.size(); i++)
         check("burst_spacing", en_cyc_q[i] - done_cyc_q[i-1], SPACE);
      check_rx("burst");

      hold = 1;
      for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1);
      wr_off();
      check("fill_full", full, 1);
      check("fill_count", count, 16);
      wr(8'hFF, 0);
      wr_off();
      check("ovf_set", overflow, 1);
      check("ovf_count", count, 16);
      hold = 0;
      wait_idle("ovf_idle");
      check("ovf_sticky", overflow, 1);
      check_rx("ovf");
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      check("rst_clears_ovf", overflow, 0);
      check("rst_count0", count, 0);

      hold = 1;
      for (int i = 0; i < 5; i++) wr(8'(8'h40 + i), 1);
      wr_off();
      check("pre_simul_count", count, 5);
      hold = 0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (tx_en) begin
            found = 1;
            break;
         end
      end
      check("simul_launch_seen", found, 1);
      wr_en = 1;
      wr_data = 8'h45;
      exp_q.push_back(8'h45);
      wr_off();
      check("simul_count", count, 5);
      wait_idle("simul_idle");
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < (c == 2 ? 10 : 12); i++) wr(8'(c * 12 * 37 + i * 37 + 5), 1);
         wr_off();
         wait_idle("wrap_idle");
      end
      check_rx("wrap");

      for (int i = 0; i < 3; i++) wr(8'(8'h70 + i), 1);
      wr_off();
      repeat (5) @(negedge clk);
      check("arst_pre_active", model_active, 1);
      frame_rst = 1;
      arst_n = 0;
      #1;
      check("arst_empty", empty, 1);
      check("arst_count", count, 0);
      check("arst_tx_en", tx_en, 0);
      check("arst_ovf", overflow, 0);
      rx_q.delete();
      exp_q.delete();
      en_cyc_q.delete();
      done_cyc_q.delete();
      @(negedge clk);
      arst_n = 1;
      repeat (10) @(negedge clk);
      check("arst_no_launch", en_cyc_q.size(), 0);
      wr(8'h3C, 1);
      wr_off();
      wait_idle("arst_idle");
      check("arst_wait_busy",
            (en_cyc_q.size() > 0 && done_cyc_q.size() > 0) ? en_cyc_q[0] - done_cyc_q[0] : -1, 1);
      check_rx("arst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
